// File: rtl/frog_mover.sv
// -----------------------------------------------------------------------------
// frog_mover
//   Player-sprite controller for the frog game. Once per frame it turns a
//   freshly pressed direction key into a single hop of STEP pixels, clamps the
//   sprite centre to the playfield, adds the external drift of whatever the
//   frog is riding on, and runs the death/respawn and goal-reached sequences.
//
// Ports
//   frame_clk  in   1   frame tick, all state changes on the rising edge
//   Reset      in   1   asynchronous, active-high
//   keycode    in   16  current key (001A up, 0004 left, 0016 down, 0007 right)
//   carry_vx   in   W   signed horizontal drift applied every live frame
//   death      in   1   collision / drowning indication
//   FrogX      out  W   sprite centre X
//   FrogY      out  W   sprite centre Y
//   FrogS      out  W   sprite half-size (constant SIZE)
//   facing     out  2   last hop direction: 00 up, 01 left, 10 down, 11 right
//   hopping    out  1   high while the post-hop cooldown runs
//   dead       out  1   high while in the death state
//   goal       out  1   one-frame pulse when the top row is reached
// -----------------------------------------------------------------------------
module frog_mover #(
  parameter int W           = 10,
  parameter int X_START     = 320,
  parameter int Y_START     = 429,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 639,
  parameter int Y_MIN       = 50,
  parameter int Y_MAX       = 438,
  parameter int STEP        = 18,
  parameter int SIZE        = 9,
  parameter int HOP_FRAMES  = 8,
  parameter int DEAD_FRAMES = 60
) (
  input  logic         frame_clk,
  input  logic         Reset,
  input  logic [15:0]  keycode,
  input  logic [W-1:0] carry_vx,
  input  logic         death,
  output logic [W-1:0] FrogX,
  output logic [W-1:0] FrogY,
  output logic [W-1:0] FrogS,
  output logic [1:0]   facing,
  output logic         hopping,
  output logic         dead,
  output logic         goal
);

  // Keyboard scan codes for the four directions.
  localparam logic [15:0] KEY_UP    = 16'h001A;
  localparam logic [15:0] KEY_LEFT  = 16'h0004;
  localparam logic [15:0] KEY_DOWN  = 16'h0016;
  localparam logic [15:0] KEY_RIGHT = 16'h0007;

  // Direction codes shared by the key decoder and the facing output.
  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  // Legal range of the sprite centre, keeping the whole sprite on screen.
  localparam int XL_I = X_MIN + SIZE;
  localparam int XH_I = X_MAX - SIZE;
  localparam int YL_I = Y_MIN + SIZE;
  localparam int YH_I = Y_MAX - SIZE;

  // Position arithmetic runs two bits wider than W and signed, so that a
  // hop plus a negative drift near the left edge, or a hop plus a large
  // positive drift near the right edge, never wraps before clamping.
  localparam logic signed [W+1:0] XL     = XL_I[W+1:0];
  localparam logic signed [W+1:0] XH     = XH_I[W+1:0];
  localparam logic signed [W+1:0] YL     = YL_I[W+1:0];
  localparam logic signed [W+1:0] YH     = YH_I[W+1:0];
  localparam logic signed [W+1:0] STEP_S = STEP[W+1:0];

  localparam logic [W-1:0] X_START_W = X_START[W-1:0];
  localparam logic [W-1:0] Y_START_W = Y_START[W-1:0];
  localparam logic [W-1:0] SIZE_W    = SIZE[W-1:0];

  // One down-counter serves both the hop cooldown and the death timer, so
  // it is sized for whichever is longer.
  localparam int CNT_MAX = (DEAD_FRAMES > HOP_FRAMES) ? DEAD_FRAMES : HOP_FRAMES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int HOP_LOAD_I  = HOP_FRAMES - 1;
  localparam int DEAD_LOAD_I = DEAD_FRAMES - 1;
  localparam logic [CW-1:0] HOP_LOAD  = HOP_LOAD_I[CW-1:0];
  localparam logic [CW-1:0] DEAD_LOAD = DEAD_LOAD_I[CW-1:0];

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOP  = 2'd1,
    DEAD = 2'd2
  } state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [15:0]    prev_key;

  logic           is_dir;
  logic [1:0]     dir;
  logic           press;
  logic           accept;

  logic signed [W+1:0] hop_dx;
  logic signed [W+1:0] hop_dy;
  logic signed [W+1:0] carry_s;
  logic signed [W+1:0] sum_x;
  logic signed [W+1:0] sum_y;
  logic signed [W+1:0] clamp_x;
  logic signed [W+1:0] clamp_y;
  logic [W-1:0]        nx;
  logic [W-1:0]        ny;
  logic                at_goal;

  assign FrogS = SIZE_W;

  // Decode the current key into a direction; anything else is not a
  // direction and can never start a hop.
  always_comb begin
    is_dir = 1'b1;
    dir    = DIR_UP;
    case (keycode)
      KEY_UP:    dir = DIR_UP;
      KEY_LEFT:  dir = DIR_LEFT;
      KEY_DOWN:  dir = DIR_DOWN;
      KEY_RIGHT: dir = DIR_RIGHT;
      default:   is_dir = 1'b0;
    endcase
  end

  // A press is any change of keycode that lands on a direction key. Holding
  // a key therefore hops once, while sliding straight from one direction key
  // to another counts as a fresh press.
  assign press  = is_dir && (keycode != prev_key);
  assign accept = press && (state == IDLE);

  // The hop offset is applied only on the frame a press is accepted; during
  // the cooldown the frog merely drifts with carry_vx.
  always_comb begin
    hop_dx = '0;
    hop_dy = '0;
    if (accept) begin
      case (dir)
        DIR_UP:    hop_dy = -STEP_S;
        DIR_LEFT:  hop_dx = -STEP_S;
        DIR_DOWN:  hop_dy = STEP_S;
        default:   hop_dx = STEP_S;
      endcase
    end
  end

  // Candidate next position: widen, add hop and drift, then clamp.
  always_comb begin
    carry_s = {{2{carry_vx[W-1]}}, carry_vx};
    sum_x   = $signed({2'b00, FrogX}) + hop_dx + carry_s;
    sum_y   = $signed({2'b00, FrogY}) + hop_dy;

    clamp_x = sum_x;
    if (sum_x < XL) begin
      clamp_x = XL;
    end else if (sum_x > XH) begin
      clamp_x = XH;
    end

    clamp_y = sum_y;
    if (sum_y < YL) begin
      clamp_y = YL;
    end else if (sum_y > YH) begin
      clamp_y = YH;
    end

    nx      = clamp_x[W-1:0];
    ny      = clamp_y[W-1:0];
    at_goal = (clamp_y == YL);
  end

  // Main controller. prev_key tracks the keyboard in every state so that a
  // key held through a cooldown or a death cannot fire once the frog is
  // free again. A death report outranks everything else that frame: the
  // position stays put and any press or goal on the same frame is dropped.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      cnt      <= '0;
      prev_key <= '0;
      FrogX    <= X_START_W;
      FrogY    <= Y_START_W;
      facing   <= DIR_UP;
      hopping  <= 1'b0;
      dead     <= 1'b0;
      goal     <= 1'b0;
    end else begin
      prev_key <= keycode;
      goal     <= 1'b0;
      case (state)
        IDLE, HOP: begin
          if (death) begin
            state   <= DEAD;
            cnt     <= DEAD_LOAD;
            dead    <= 1'b1;
            hopping <= 1'b0;
          end else if (at_goal) begin
            // Reaching the top row sends the frog home and still imposes
            // the usual cooldown before the next hop.
            FrogX   <= X_START_W;
            FrogY   <= Y_START_W;
            facing  <= DIR_UP;
            goal    <= 1'b1;
            state   <= HOP;
            cnt     <= HOP_LOAD;
            hopping <= 1'b1;
          end else begin
            FrogX <= nx;
            FrogY <= ny;
            if (accept) begin
              // A hop blocked by the edge still turns the frog and costs a
              // full cooldown.
              facing  <= dir;
              state   <= HOP;
              cnt     <= HOP_LOAD;
              hopping <= 1'b1;
            end else if (state == HOP) begin
              if (cnt == '0) begin
                state   <= IDLE;
                hopping <= 1'b0;
              end else begin
                cnt <= cnt - 1'b1;
              end
            end
          end
        end
        DEAD: begin
          // Position, keys and drift are all ignored while dead; the
          // respawn lands on the last edge of the death interval.
          if (cnt == '0) begin
            state  <= IDLE;
            dead   <= 1'b0;
            FrogX  <= X_START_W;
            FrogY  <= Y_START_W;
            facing <= DIR_UP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          cnt     <= '0;
          hopping <= 1'b0;
          dead    <= 1'b0;
        end
      endcase
    end
  end

endmodule
